// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch stage.
// Reads two consecutive bytes from the registered-output program ROM and
// assembles them into a big-endian opcode. The opcode is offered to the
// decoder over valid/ready. This block owns the program counter, including
// skip advances and jump/call/return redirects.
module chip8_fetch #(
  parameter logic [11:0] RESET_PC = 12'h200
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_dout,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic        op_skip,
  input  logic        pc_load,
  input  logic [11:0] pc_load_addr,
  output logic [15:0] opcode,
  output logic [11:0] op_pc,
  output logic [11:0] pc
);

  typedef enum logic [1:0] {FETCH_HI, FETCH_LO, CAPTURE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [11:0] op_pc_q, op_pc_d;
  logic [15:0] opcode_q, opcode_d;
  logic        valid_q, valid_d;

  // The decoder consumes the opcode only while it is being held.
  logic accept;
  assign accept = (state_q == HOLD) && op_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH_HI;
    else     state_q <= state_d;
  end

  // Next state: fixed three-cycle fetch, then hold until accepted.
  // A redirect always restarts the fetch and discards any partial bytes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_HI: state_d = FETCH_LO;
      FETCH_LO: state_d = CAPTURE;
      CAPTURE:  state_d = HOLD;
      HOLD:     if (op_ready) state_d = FETCH_HI;
      default:  state_d = FETCH_HI;
    endcase
    if (pc_load) state_d = FETCH_HI;
  end

  // ROM address: the low byte is requested in FETCH_LO and CAPTURE.
  // The sum is 12 bits wide, so 0xFFF wraps to 0x000.
  always_comb begin
    rom_addr = pc_q;
    if (state_q == FETCH_LO || state_q == CAPTURE) rom_addr = pc_q + 12'd1;
  end

  // Datapath next-state logic. ROM data lags the address by one cycle,
  // so the high byte arrives in FETCH_LO and the low byte in CAPTURE.
  always_comb begin
    pc_d     = pc_q;
    op_pc_d  = op_pc_q;
    opcode_d = opcode_q;
    valid_d  = valid_q;
    if (pc_load) begin
      // A redirect wins over an accept in the same cycle. The held opcode
      // still counts as consumed, but the pc takes the target.
      pc_d    = pc_load_addr;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        FETCH_LO: opcode_d[15:8] = rom_dout;
        CAPTURE: begin
          opcode_d[7:0] = rom_dout;
          op_pc_d       = pc_q;
          valid_d       = 1'b1;
        end
        HOLD: if (accept) begin
          valid_d = 1'b0;
          pc_d    = pc_q + (op_skip ? 12'd4 : 12'd2);
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      op_pc_q  <= 12'h000;
      opcode_q <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      op_pc_q  <= op_pc_d;
      opcode_q <= opcode_d;
      valid_q  <= valid_d;
    end
  end

  assign op_valid = valid_q;
  assign opcode   = opcode_q;
  assign op_pc    = op_pc_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_chip8_fetch.sv
// Directed bench for chip8_fetch: a per-cycle vector table covering the
// normal fetch, backpressure and skip, followed by hand-written sequences
// for redirect, wrap and reset-in-hold.
module tb_chip8_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] rom_addr;
  logic [7:0]  rom_dout;
  logic        op_valid, op_ready, op_skip, pc_load;
  logic [11:0] pc_load_addr;
  logic [15:0] opcode;
  logic [11:0] op_pc, pc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:4095];

  chip8_fetch #(.RESET_PC(12'h200)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .op_valid(op_valid), .op_ready(op_ready), .op_skip(op_skip),
    .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .opcode(opcode), .op_pc(op_pc), .pc(pc)
  );

  always #5 clk = ~clk;

  // Behavioural ROM with a one-cycle registered read.
  always @(posedge clk) rom_dout <= mem[rom_addr];

  typedef struct {
    logic        rdy, skp;
    logic        exp_v, chk_op;
    logic [15:0] exp_op;
    logic [11:0] exp_oppc, exp_pc, exp_ra;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rdy, logic skp, logic v, logic cop,
                              logic [15:0] op, logic [11:0] oppc,
                              logic [11:0] p, logic [11:0] ra);
    vec_t t;
    t.rdy = rdy; t.skp = skp; t.exp_v = v; t.chk_op = cop;
    t.exp_op = op; t.exp_oppc = oppc; t.exp_pc = p; t.exp_ra = ra;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 (first FETCH_HI) with inputs idle.
  task automatic do_reset();
    rst = 1'b1; op_ready = 1'b0; op_skip = 1'b0; pc_load = 1'b0;
    pc_load_addr = 12'h000;
    step(); step();
    rst = 1'b0;
  endtask

  int cnt;

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    mem[12'h202] = 8'h56; mem[12'h203] = 8'h78;
    mem[12'h204] = 8'h9A; mem[12'h205] = 8'hBC;
    mem[12'h206] = 8'h11; mem[12'h207] = 8'h22;
    mem[12'h208] = 8'hDE; mem[12'h209] = 8'hF0;
    mem[12'h300] = 8'hAB; mem[12'h301] = 8'hCD;
    mem[12'hFFF] = 8'hA5; mem[12'h000] = 8'h5A;
    mem[12'h001] = 8'h77; mem[12'h002] = 8'h88;

    // ---- table: reset, first fetch, backpressure, skip ----
    //            rdy  skp  v  cop  opcode    op_pc    pc       rom_addr
    vt.push_back(mk(1, 0, 0, 1, 16'h0000, 12'h000, 12'h200, 12'h200));
    vt.push_back(mk(1, 0, 0, 1, 16'h0000, 12'h000, 12'h200, 12'h201));
    vt.push_back(mk(1, 0, 0, 0, 16'h0000, 12'h000, 12'h200, 12'h201));
    vt.push_back(mk(1, 0, 1, 1, 16'h1234, 12'h200, 12'h200, 12'h200));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 12'h200, 12'h202, 12'h202));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 12'h200, 12'h202, 12'h203));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 12'h200, 12'h202, 12'h203));
    for (int k = 0; k < 6; k++)
      vt.push_back(mk(0, 0, 1, 1, 16'h5678, 12'h202, 12'h202, 12'h202));
    vt.push_back(mk(1, 0, 1, 1, 16'h5678, 12'h202, 12'h202, 12'h202));
    vt.push_back(mk(1, 1, 0, 0, 16'h0000, 12'h202, 12'h204, 12'h204));
    vt.push_back(mk(1, 1, 0, 0, 16'h0000, 12'h202, 12'h204, 12'h205));
    vt.push_back(mk(1, 1, 0, 0, 16'h0000, 12'h202, 12'h204, 12'h205));
    vt.push_back(mk(1, 1, 1, 1, 16'h9ABC, 12'h204, 12'h204, 12'h204));
    vt.push_back(mk(1, 0, 0, 0, 16'h0000, 12'h204, 12'h208, 12'h208));
    vt.push_back(mk(1, 0, 0, 0, 16'h0000, 12'h204, 12'h208, 12'h209));
    vt.push_back(mk(1, 0, 0, 0, 16'h0000, 12'h204, 12'h208, 12'h209));
    vt.push_back(mk(0, 0, 1, 1, 16'hDEF0, 12'h208, 12'h208, 12'h208));

    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      chk($sformatf("v%0d op_valid", i), {15'd0, op_valid}, {15'd0, vt[i].exp_v});
      if (vt[i].chk_op) chk($sformatf("v%0d opcode", i), opcode, vt[i].exp_op);
      chk($sformatf("v%0d op_pc", i), {4'd0, op_pc}, {4'd0, vt[i].exp_oppc});
      chk($sformatf("v%0d pc", i), {4'd0, pc}, {4'd0, vt[i].exp_pc});
      chk($sformatf("v%0d rom_addr", i), {4'd0, rom_addr}, {4'd0, vt[i].exp_ra});
      op_ready = vt[i].rdy;
      op_skip  = vt[i].skp;
      step();
    end
    op_ready = 1'b0; op_skip = 1'b0;

    // ---- redirect during FETCH_LO of 0x200 ----
    do_reset();
    step();                          // cycle 1: FETCH_LO
    pc_load = 1'b1; pc_load_addr = 12'h300;
    step();                          // cycle 2
    pc_load = 1'b0;
    chk("redir rom_addr", {4'd0, rom_addr}, 16'h0300);
    chk("redir pc", {4'd0, pc}, 16'h0300);
    chk("redir op_valid", {15'd0, op_valid}, 16'h0000);
    cnt = 2;
    while (cnt < 12 && !op_valid) begin
      step();
      cnt++;
    end
    chk("redir valid cycle", cnt[15:0], 16'd5);
    chk("redir op_pc", {4'd0, op_pc}, 16'h0300);
    chk("redir opcode", opcode, 16'hABCD);

    // ---- redirect coincident with accept ----
    op_ready = 1'b1; pc_load = 1'b1; pc_load_addr = 12'h300;
    step();
    op_ready = 1'b0; pc_load = 1'b0;
    chk("coinc pc", {4'd0, pc}, 16'h0300);
    chk("coinc op_valid", {15'd0, op_valid}, 16'h0000);
    chk("coinc rom_addr", {4'd0, rom_addr}, 16'h0300);

    // ---- wrap at the top of memory ----
    pc_load = 1'b1; pc_load_addr = 12'hFFF;
    step();                          // N+1
    pc_load = 1'b0;
    chk("wrap ra hi", {4'd0, rom_addr}, 16'h0FFF);
    step();                          // N+2
    chk("wrap ra lo", {4'd0, rom_addr}, 16'h0000);
    step();                          // N+3
    chk("wrap valid early", {15'd0, op_valid}, 16'h0000);
    step();                          // N+4
    chk("wrap op_valid", {15'd0, op_valid}, 16'h0001);
    chk("wrap opcode", opcode, 16'hA55A);
    chk("wrap op_pc", {4'd0, op_pc}, 16'h0FFF);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    chk("wrap pc", {4'd0, pc}, 16'h0001);
    chk("wrap valid drop", {15'd0, op_valid}, 16'h0000);
    step(); step(); step();
    chk("wrap next valid", {15'd0, op_valid}, 16'h0001);
    chk("wrap next opcode", opcode, 16'h7788);

    // ---- reset while holding a valid opcode ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rsthold op_valid", {15'd0, op_valid}, 16'h0000);
    chk("rsthold opcode", opcode, 16'h0000);
    chk("rsthold op_pc", {4'd0, op_pc}, 16'h0000);
    chk("rsthold pc", {4'd0, pc}, 16'h0200);
    chk("rsthold rom_addr", {4'd0, rom_addr}, 16'h0200);
    step(); step(); step();
    chk("rsthold refetch valid", {15'd0, op_valid}, 16'h0001);
    chk("rsthold refetch opcode", opcode, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
